instr_sequencer: RTL and testbench

Multi-cycle sequencer for the 9-bit processor core.
- Steps each instruction through fetch, execute and optional data-memory phases.
- Latches the instruction register and the comparison flags.
- Converts the level-type enables of the combinational `control` decoder into single-cycle write/advance strobes.
- Sits between the instruction ROM, `control`, the register file, the PC and data memory.

---
 rtl/instr_sequencer_pkg.sv | 16 +
 rtl/instr_sequencer_sat_counter.sv | 22 ++
 rtl/instr_sequencer.sv | 127 ++++++++++++
 tb/tb_instr_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instr_sequencer block.
package seq_pkg;

    localparam int INSTR_W = 9;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;
    localparam logic [2:0] CMP_OP = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM,
        HALT
    } seq_state_t;

endpackage

// File: rtl/instr_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute/memory sequencer for the 9-bit core.
// Optional retired-instruction counter built when SEQ_RETIRE_CNT_EN is defined.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    input  logic               ctl_reg_wr_en,
    input  logic               ctl_dat_wr_en,
    input  logic               ctl_reg_alu_dat_sel,
    input  logic [2:0]         alu_flags,
    input  logic               dat_ack,
    output logic [INSTR_W-1:0] ir,
    output logic [2:0]         flags_q,
    output logic               pc_clr,
    output logic               pc_en,
    output logic               reg_wr,
    output logic               dat_req,
    output logic               dat_wr,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   retired
);

    seq_state_t state, state_nxt;
    logic       flag_ld;
    logic       seq_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // pc_clr is gated with reset so a start held during reset cannot leak a strobe.
    always_comb begin
        state_nxt = state;
        pc_clr    = 1'b0;
        pc_en     = 1'b0;
        reg_wr    = 1'b0;
        dat_req   = 1'b0;
        dat_wr    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        flag_ld   = 1'b0;
        seq_clr   = 1'b0;
        case (state)
            IDLE: begin
                seq_clr = 1'b1;
                if (start) begin
                    pc_clr    = ~reset;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                busy      = 1'b1;
                state_nxt = (instr == HALT_INSTR) ? HALT : EXEC;
            end
            EXEC: begin
                busy = 1'b1;
                if (ctl_reg_alu_dat_sel || ctl_dat_wr_en) begin
                    state_nxt = MEM;
                end else begin
                    reg_wr    = ctl_reg_wr_en;
                    pc_en     = 1'b1;
                    flag_ld   = (ir[8:6] == CMP_OP);
                    state_nxt = FETCH;
                end
            end
            MEM: begin
                busy    = 1'b1;
                dat_req = 1'b1;
                dat_wr  = ctl_dat_wr_en;
                if (dat_ack) begin
                    reg_wr    = ctl_reg_wr_en;
                    pc_en     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            HALT: begin
                done = 1'b1;
                if (start) begin
                    pc_clr    = ~reset;
                    seq_clr   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir      <= '0;
            flags_q <= '0;
        end else begin
            if (state == FETCH) begin
                ir <= instr;
            end
            if (seq_clr) begin
                flags_q <= '0;
            end else if (flag_ld) begin
                flags_q <= alu_flags;
            end
        end
    end

    // Every retiring cycle is exactly a pc_en cycle, so it doubles as the count enable.
`ifdef SEQ_RETIRE_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (seq_clr),
        .inc   (pc_en),
        .count (retired)
    );
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer using a per-instruction expectation queue.
module tb_instr_sequencer;

    localparam int CNT_W = 3;

    typedef struct {
        int          lat;
        int          memc;
        logic        dat_wr;
        logic        reg_wr;
        logic [2:0]  flags;
        logic [CNT_W-1:0] retired;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [8:0]       instr;
    logic             ctl_reg_wr_en;
    logic             ctl_dat_wr_en;
    logic             ctl_reg_alu_dat_sel;
    logic [2:0]       alu_flags;
    logic             dat_ack;
    logic [8:0]       ir;
    logic [2:0]       flags_q;
    logic             pc_clr;
    logic             pc_en;
    logic             reg_wr;
    logic             dat_req;
    logic             dat_wr;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] retired;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic [2:0] m_flags;
    int   m_retired;

    always #5 clk = ~clk;

    instr_sequencer #(.CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .instr               (instr),
        .ctl_reg_wr_en       (ctl_reg_wr_en),
        .ctl_dat_wr_en       (ctl_dat_wr_en),
        .ctl_reg_alu_dat_sel (ctl_reg_alu_dat_sel),
        .alu_flags           (alu_flags),
        .dat_ack             (dat_ack),
        .ir                  (ir),
        .flags_q             (flags_q),
        .pc_clr              (pc_clr),
        .pc_en               (pc_en),
        .reg_wr              (reg_wr),
        .dat_req             (dat_req),
        .dat_wr              (dat_wr),
        .busy                (busy),
        .done                (done),
        .retired             (retired)
    );

    function automatic logic [CNT_W-1:0] exp_ret();
`ifdef SEQ_RETIRE_CNT_EN
        return m_retired[CNT_W-1:0];
`else
        return '0;
`endif
    endfunction

    // Entered at posedge+1 in IDLE or HALT; leaves at posedge+1 in FETCH.
    task automatic do_start();
        start = 1'b1;
        #1;
        checks++;
        if (pc_clr !== 1'b1) begin errors++; $display("FAIL start_pc_clr got=%b want=1", pc_clr); end
        @(posedge clk); #1;
        start = 1'b0;
        m_flags = 3'b000;
        m_retired = 0;
        checks++;
        if (busy !== 1'b1 || pc_clr !== 1'b0) begin
            errors++; $display("FAIL start_fetch busy=%b pc_clr=%b want busy=1 pc_clr=0", busy, pc_clr);
        end
        checks++;
        if (flags_q !== 3'b000 || retired !== '0) begin
            errors++; $display("FAIL start_clear flags_q=%b retired=%0d want 0/0", flags_q, retired);
        end
    endtask

    // Entered in FETCH at posedge+1; runs one instruction through retirement.
    task automatic run_instr(input logic [8:0] op, input logic rwe, input logic dwe,
                             input logic sel, input logic [2:0] fl, input int waitc);
        exp_t e, g;
        int   cyc, memc, got_pc;
        logic dw_seen, rw_seen, spur;
        instr = op; ctl_reg_wr_en = rwe; ctl_dat_wr_en = dwe;
        ctl_reg_alu_dat_sel = sel; alu_flags = fl;
        if (!(sel || dwe) && op[8:6] == 3'b000) m_flags = fl;
        if (m_retired < (1 << CNT_W) - 1) m_retired++;
        e.lat = (sel || dwe) ? 3 + waitc : 2;
        e.memc = (sel || dwe) ? waitc + 1 : 0;
        e.dat_wr = dwe; e.reg_wr = rwe; e.flags = m_flags; e.retired = exp_ret();
        sb.push_back(e);
        cyc = 0; memc = 0; got_pc = 0; dw_seen = 0; rw_seen = 0; spur = 0;
        while (!got_pc && cyc < 40) begin
            cyc++;
            dat_ack = 1'b0;
            #1;
            if (dat_req) begin
                dw_seen = dat_wr;
                if (memc == waitc) dat_ack = 1'b1;
                memc++;
                #1;
            end
            if (pc_en) begin got_pc = 1; rw_seen = reg_wr; end
            else if (reg_wr) spur = 1;
            @(posedge clk); #1;
        end
        dat_ack = 1'b0;
        g = sb.pop_front();
        checks++;
        if (got_pc != 1 || cyc != g.lat) begin
            errors++; $display("FAIL latency op=%h got=%0d retired=%0d want=%0d", op, cyc, got_pc, g.lat);
        end
        checks++;
        if (memc != g.memc || dw_seen !== g.dat_wr) begin
            errors++; $display("FAIL dat_req op=%h cycles=%0d dat_wr=%b want %0d/%b", op, memc, dw_seen, g.memc, g.dat_wr);
        end
        checks++;
        if (rw_seen !== g.reg_wr || spur) begin
            errors++; $display("FAIL reg_wr op=%h got=%b spurious=%b want=%b", op, rw_seen, spur, g.reg_wr);
        end
        checks++;
        if (flags_q !== g.flags) begin
            errors++; $display("FAIL flags_q op=%h got=%b want=%b", op, flags_q, g.flags);
        end
        checks++;
        if (retired !== g.retired || ir !== op) begin
            errors++; $display("FAIL retired_ir op=%h retired=%0d ir=%h want %0d/%h", op, retired, ir, g.retired, op);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; instr = '0; ctl_reg_wr_en = 0; ctl_dat_wr_en = 0;
        ctl_reg_alu_dat_sel = 0; alu_flags = '0; dat_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pc_clr, pc_en, reg_wr, dat_req, dat_wr, busy, done} !== 7'b0 || ir !== '0
            || flags_q !== '0 || retired !== '0) begin
            errors++; $display("FAIL reset_state strobes=%b ir=%h flags=%b retired=%0d want all 0",
                {pc_clr, pc_en, reg_wr, dat_req, dat_wr, busy, done}, ir, flags_q, retired);
        end
        start = 1'b0; dat_ack = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL idle_hold busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_alu_op();
        do_start();
        run_instr(9'b010000_001, 1'b1, 1'b0, 1'b0, 3'b100, 0);
    endtask

    task automatic test_cmp_then_add();
        run_instr(9'b000000_010, 1'b0, 1'b0, 1'b0, 3'b001, 0);
        run_instr(9'b010000_011, 1'b1, 1'b0, 1'b0, 3'b100, 0);
    endtask

    task automatic test_load_wait();
        run_instr(9'b100000_011, 1'b1, 1'b0, 1'b1, 3'b010, 3);
    endtask

    task automatic test_store();
        run_instr(9'b101000_100, 1'b0, 1'b1, 1'b0, 3'b110, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) run_instr(9'b011000_000 | 9'(i), 1'b1, 1'b0, 1'b0, 3'b111, 0);
    endtask

    task automatic test_halt_restart();
        logic [CNT_W-1:0] r0;
        r0 = retired;
        instr = 9'h1FF; ctl_reg_wr_en = 1'b0; ctl_dat_wr_en = 1'b0; ctl_reg_alu_dat_sel = 1'b0;
        #1;
        checks++;
        if (pc_en !== 1'b0) begin errors++; $display("FAIL halt_fetch_pc_en got=%b want=0", pc_en); end
        @(posedge clk); #1;
        dat_ack = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || retired !== r0 || pc_en !== 1'b0) begin
            errors++; $display("FAIL halt_state done=%b busy=%b retired=%0d pc_en=%b want 1/0/%0d/0",
                done, busy, retired, pc_en, r0);
        end
        dat_ack = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || flags_q !== m_flags) begin
            errors++; $display("FAIL halt_persist done=%b flags_q=%b want 1/%b", done, flags_q, m_flags);
        end
        do_start();
        run_instr(9'b000000_101, 1'b0, 1'b0, 1'b0, 3'b010, 0);
    endtask

    task automatic test_reset_mid_mem();
        int n;
        instr = 9'b100000_110; ctl_reg_wr_en = 1'b1; ctl_dat_wr_en = 1'b0; ctl_reg_alu_dat_sel = 1'b1;
        dat_ack = 1'b0;
        n = 0;
        while (dat_req !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
        checks++;
        if (dat_req !== 1'b1) begin errors++; $display("FAIL mem_reach dat_req=%b want=1", dat_req); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (dat_req !== 1'b1 || pc_clr !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL start_in_mem dat_req=%b pc_clr=%b busy=%b want 1/0/1", dat_req, pc_clr, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({pc_clr, pc_en, reg_wr, dat_req, dat_wr, busy, done} !== 7'b0 || ir !== '0
            || flags_q !== '0 || retired !== '0) begin
            errors++; $display("FAIL async_reset strobes=%b ir=%h flags=%b retired=%0d want all 0",
                {pc_clr, pc_en, reg_wr, dat_req, dat_wr, busy, done}, ir, flags_q, retired);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    initial begin
        m_flags = '0;
        m_retired = 0;
        test_reset();
        test_alu_op();
        test_cmp_then_add();
        test_load_wait();
        test_store();
        test_back_to_back();
        test_halt_restart();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
